// File: rtl/uart_tx_sink.sv
// uart_tx_sink: buffers bytes written by the core in a small FIFO and
// serialises them onto the board TX pin as 8N1 UART frames, LSB first.
// Frames go out back-to-back while the FIFO holds data, so the core never
// has to wait on a transmit instruction.
module uart_tx_sink #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_ready_i,
  input  logic [7:0]            sdata_i,
  output logic                  txd_o,
  output logic                  busy_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o
);

  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0]     BAUD_ONE   = BAUD_W'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]            fifoMem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q;
  logic [DEPTH_LOG2-1:0] rdPtr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  overflow_q;

  state_e                state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [2:0]            bitIdx_q;
  logic [7:0]            shift_q;
  logic                  txd_q;

  logic                  fifoEmpty;
  logic                  fifoFull;
  logic                  baudLast;
  logic                  push;
  logic                  pop;
  logic [7:0]            headByte;

  // A write is judged against the occupancy before the edge, so a pop in the
  // same cycle never frees a slot for the incoming byte.
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == COUNT_FULL);
  assign baudLast  = (baud_q == BAUD_LAST);
  assign push      = tx_ready_i & ~fifoFull;
  assign pop       = ~fifoEmpty & ((state_q == IDLE) | ((state_q == STOP) & baudLast));
  assign headByte  = fifoMem_q[rdPtr_q];

  assign txd_o      = txd_q;
  assign busy_o     = (state_q != IDLE) | ~fifoEmpty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  // Next occupancy: a simultaneous write and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + COUNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  // FIFO storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= sdata_i;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PTR_ONE;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_ONE;
      end
      if (tx_ready_i && fifoFull) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Frame serialiser; txd is registered so the line never glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= headByte;
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baudLast) begin
            baud_q   <= '0;
            bitIdx_q <= '0;
            txd_q    <= shift_q[0];
            state_q  <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        DATA: begin
          if (baudLast) begin
            baud_q <= '0;
            if (bitIdx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              shift_q  <= {1'b0, shift_q[7:1]};
              txd_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        STOP: begin
          if (baudLast) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= headByte;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sink.sv
// tb_uart_tx_sink: drives uart_tx_sink with directed and random byte strobes,
// predicts the line from a frame-position model and decodes it as a UART.
module tb_uart_tx_sink;

  localparam int CPB   = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk;
  logic        rst;
  logic        txReady;
  logic [7:0]  sdata;
  logic        txd;
  logic        busy;
  logic [2:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state: queue of buffered bytes plus the position inside
  // the frame currently on the line.
  logic [7:0] mQ[$];
  logic [7:0] expRx[$];
  logic [7:0] gotRx[$];
  bit         mActive = 0;
  int         mFc = 0;
  logic [7:0] mByte = '0;
  bit         mOvf = 0;
  bit         modelValid = 0;
  int         mSz;
  bit         doPop;
  bit         doPush;

  bit         decActive = 0;
  int         decCnt = 0;
  logic [7:0] decByte = '0;

  uart_tx_sink #(
    .CLKS_PER_BIT(CPB),
    .DEPTH_LOG2  (DL)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_ready_i(txReady),
    .sdata_i   (sdata),
    .txd_o     (txd),
    .busy_o    (busy),
    .count_o   (count),
    .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One write strobe (or idle cycle), ending 1 time unit after the edge.
  task automatic applyStimulus(input logic tr, input logic [7:0] d);
    txReady = tr;
    sdata   = d;
    @(posedge clk);
    #1;
    txReady = 1'b0;
    sdata   = 8'($urandom);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (busy === 1'b1 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("idle_reached", busy, 0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Line level implied by the frame position: start bit, 8 data bits LSB first, stop bit.
  function automatic logic modelTxd();
    int pos;
    if (!mActive) return 1'b1;
    pos = mFc / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return mByte[pos-1];
  endfunction

  // Model update at each edge, using the occupancy seen before the edge.
  always @(posedge clk) begin
    if (rst) begin
      mQ.delete();
      mActive    = 0;
      mFc        = 0;
      mOvf       = 0;
      modelValid = 1;
    end else begin
      mSz    = mQ.size();
      doPop  = (mSz != 0) && (!mActive || mFc == FRAME - 1);
      doPush = (txReady === 1'b1) && (mSz < DEPTH);
      if (txReady === 1'b1 && !doPush) mOvf = 1;
      if (mActive && mFc == FRAME - 1) expRx.push_back(mByte);
      if (doPop) begin
        mByte   = mQ.pop_front();
        mActive = 1;
        mFc     = 0;
      end else if (mActive) begin
        if (mFc == FRAME - 1) mActive = 0;
        else mFc++;
      end
      if (doPush) mQ.push_back(sdata);
    end
  end

  // Every cycle the outputs are compared with the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("txd", txd, modelTxd());
      checkOutput("busy", busy, (mActive || mQ.size() != 0));
      checkOutput("count", count, mQ.size());
      checkOutput("overflow", overflow, mOvf);
    end
  end

  // Independent UART receiver sampling mid-bit.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      decActive = 0;
    end else if (!decActive) begin
      if (txd === 1'b0) begin
        decActive = 1;
        decCnt    = 0;
      end
    end else begin
      decCnt++;
      if ((decCnt % CPB) == CPB / 2 && decCnt / CPB >= 1 && decCnt / CPB <= 8)
        decByte[decCnt/CPB-1] = txd;
      if (decCnt == 9 * CPB + CPB / 2) begin
        checkOutput("stop_bit", txd, 1);
        gotRx.push_back(decByte);
        decActive = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [39:0] wave;
    logic [7:0]  b2b[3];
    logic [7:0]  xByte;
    logic [7:0]  yByte;
    logic [7:0]  zByte;
    int          base;
    int          busyCycles;
    int          peak;
    int          guard;
    bit          allOnes;

    rst     = 1'b1;
    txReady = 1'b0;
    sdata   = 8'h00;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_overflow", overflow, 0);
    rst = 1'b0;
    allOnes = 1;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) allOnes = 0;
    end
    checkOutput("idle_txd_100", allOnes, 1);

    // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop.
    base = gotRx.size();
    wave = {4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000,
            4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    applyStimulus(1'b1, 8'h55);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("wave55_%0d", c), txd, wave[39-c]);
    end
    checkOutput("busy_n40", busy, 1);
    @(posedge clk);
    #1;
    checkOutput("busy_n41", busy, 0);
    checkOutput("rx55_len", gotRx.size(), base + 1);
    if (gotRx.size() > base) checkOutput("rx55", gotRx[base], 8'h55);

    // Back-to-back frames with no idle gap.
    base = gotRx.size();
    b2b[0] = 8'hA3;
    b2b[1] = 8'h00;
    b2b[2] = 8'hFF;
    busyCycles = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, b2b[i]);
      if (busy === 1'b1) busyCycles++;
    end
    guard = 0;
    while (busy === 1'b1 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
      if (busy === 1'b1) busyCycles++;
    end
    checkOutput("b2b_busy_cycles", busyCycles, 121);
    checkOutput("b2b_len", gotRx.size(), base + 3);
    for (int i = 0; i < 3; i++)
      if (gotRx.size() > base + i) checkOutput($sformatf("b2b_rx%0d", i), gotRx[base+i], b2b[i]);

    // Overflow: six strobes into a four-entry FIFO.
    base = gotRx.size();
    peak = 0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 8'(i));
      if (int'(count) > peak) peak = int'(count);
      if (i == 5) checkOutput("ovf_after5", overflow, 0);
      if (i == 6) checkOutput("ovf_after6", overflow, 1);
    end
    checkOutput("ovf_peak", peak, 4);
    waitIdle();
    checkOutput("ovf_len", gotRx.size(), base + 5);
    for (int i = 0; i < 5; i++)
      if (gotRx.size() > base + i) checkOutput($sformatf("ovf_rx%0d", i), gotRx[base+i], i + 1);

    // Full FIFO with a strobe on the STOP-end pop edge.
    pulseReset();
    checkOutput("sim_rst_ovf", overflow, 0);
    base = gotRx.size();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h11 * (i + 1)));
    checkOutput("sim_full", count, 4);
    repeat (36) begin
      @(posedge clk);
      #1;
    end
    checkOutput("sim_pre_count", count, 4);
    checkOutput("sim_pre_ovf", overflow, 0);
    applyStimulus(1'b1, 8'h66);
    checkOutput("sim_post_count", count, 3);
    checkOutput("sim_post_ovf", overflow, 1);
    waitIdle();
    checkOutput("sim_len", gotRx.size(), base + 5);
    for (int i = 0; i < 5; i++)
      if (gotRx.size() > base + i) checkOutput($sformatf("sim_rx%0d", i), gotRx[base+i], 8'h11 * (i + 1));

    // Reset during data bit 3 of a frame with a byte still queued.
    base  = gotRx.size();
    xByte = 8'($urandom);
    yByte = 8'($urandom);
    zByte = 8'($urandom);
    applyStimulus(1'b1, xByte);
    applyStimulus(1'b1, yByte);
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_txd", txd, 1);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_nodecode", gotRx.size(), base);
    applyStimulus(1'b1, zByte);
    waitIdle();
    checkOutput("midrst_len", gotRx.size(), base + 1);
    if (gotRx.size() > base) checkOutput("midrst_rx", gotRx[base], zByte);

    // Random traffic.
    repeat (800) applyStimulus($urandom_range(0, 99) < 30, 8'($urandom));
    waitIdle();

    checkOutput("rx_total", gotRx.size(), expRx.size());
    for (int i = 0; i < gotRx.size() && i < expRx.size(); i++)
      checkOutput($sformatf("rx_%0d", i), gotRx[i], expRx[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
